// File: rtl/uart_rx.sv
// uart_rx - 8N1 serial receiver for the APB UART.
//
// Samples an asynchronous serial line through a two-flop synchronizer,
// locates the start bit, samples each data bit at mid-bit (LSB first),
// checks the stop bit and reports the result to the register block.
// It shares CLK_FREQ/BAUD_RATE with the transmitter, so TX can be looped
// straight back into RX.
//
// Parameters
//   CLK_FREQ   system clock in Hz
//   BAUD_RATE  line bit rate in Hz (TICK = CLK_FREQ/BAUD_RATE, 4..65535)
//
// Ports
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset
//   rx         asynchronous serial input, idle high
//   rx_data    last correctly framed byte, held until the next good frame
//   rx_valid   one-cycle strobe, rx_data updated in the same cycle
//   frame_err  one-cycle strobe, stop bit sampled low
//   rx_busy    high while the receiver is not idle
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int TICK = CLK_FREQ / BAUD_RATE;
  localparam int HALF = TICK / 2;

  localparam logic [15:0] TICK_M1 = 16'(TICK - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [7:0]  sh;
  logic        s1;
  logic        rx_s;

  // Synchronizer stage: rx -> s1 -> rx_s; both flops idle high so a
  // reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= rx;
      rx_s <= s1;
    end
  end

  // Receive state machine; all decisions use the synchronized line only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 4'd0;
      sh        <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= 16'd0;
            rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == HALF_M1) begin
            cnt <= 16'd0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 4'd0;
            end else begin
              // Line went high again before mid start bit: a glitch.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (cnt == TICK_M1) begin
            sh      <= {rx_s, sh[7:1]};
            bit_idx <= bit_idx + 4'd1;
            cnt     <= 16'd0;
            if (bit_idx == 4'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        STOP: begin
          if (cnt == TICK_M1) begin
            cnt <= 16'd0;
            if (rx_s) begin
              // Leaving at mid stop bit lets a zero-gap next start bit
              // be seen on time.
              rx_data  <= sh;
              rx_valid <= 1'b1;
              state    <= IDLE;
              rx_busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        BREAK: begin
          // Hold off until the line returns high so a stuck-low line
          // cannot produce a stream of bogus frames.
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= 16'd0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx at TICK=16, HALF=8.
//
// A behavioural line driver sends 8N1 frames; for every frame the bench
// predicts the strobe type, the byte shown on rx_data and the cycle the
// strobe appears, from the frame start time and the documented latency.
// A monitor logs every strobe actually seen; the two lists are compared.
module tb_uart_rx;

  localparam int TICK = 16;
  localparam int HALF = TICK / 2;
  // Drive cycle of the start bit to the cycle the strobe is visible:
  // one edge to reach s1, two more to reach START, then HALF + 9*TICK.
  localparam int LAT  = 3 + HALF + 9 * TICK;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [7:0] d;
    logic       fe;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  ev_t        obs_e;
  logic [7:0] model_data = 8'h00;
  logic       prev_strobe = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      chk("strobe_excl", {31'd0, rx_valid & frame_err}, 32'd0);
      chk("strobe_width", {31'd0, prev_strobe}, 32'd0);
      obs_e.t  = cyc;
      obs_e.d  = rx_data;
      obs_e.fe = frame_err;
      obs_q.push_back(obs_e);
    end
    prev_strobe = rx_valid | frame_err;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(TICK);
  endtask

  // Sends one frame starting now; stop selects a good or bad stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    ev_t e;
    e.t  = cyc + LAT;
    e.d  = stop ? b : model_data;
    e.fe = ~stop;
    exp_q.push_back(e);
    if (stop) model_data = b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cycle"}, obs_q[i].t, exp_q[i].t);
      chk({tag, "_data"},  {24'd0, obs_q[i].d}, {24'd0, exp_q[i].d});
      chk({tag, "_ferr"},  {31'd0, obs_q[i].fe}, {31'd0, exp_q[i].fe});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] fr;

    // Reset defaults
    resetn = 1'b0;
    rx     = 1'b1;
    idle(3);
    resetn = 1'b1;
    chk("rst_data",  {24'd0, rx_data}, 32'd0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
    chk("rst_busy",  {31'd0, rx_busy}, 32'd0);
    for (int i = 0; i < 100; i++) begin
      idle(1);
      chk("idle_busy", {31'd0, rx_busy}, 32'd0);
    end
    compare("idle");

    // Single byte
    send_frame(8'hA5, 1'b1);
    idle(5);
    compare("single");
    chk("single_rx_data", {24'd0, rx_data}, 32'h0000_00A5);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(5);
    compare("b2b");

    // Framing error, then line held low
    send_frame(8'h55, 1'b0);
    idle(400);
    chk("break_busy", {31'd0, rx_busy}, 32'd1);
    chk("break_data", {24'd0, rx_data}, 32'h0000_003C);
    compare("ferr");
    rx = 1'b1;
    idle(4);
    chk("break_exit_busy", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h81, 1'b1);
    idle(5);
    compare("after_break");

    // Short start glitch
    rx = 1'b0;
    idle(3);
    chk("glitch_busy_hi", {31'd0, rx_busy}, 32'd1);
    rx = 1'b1;
    idle(10);
    chk("glitch_busy_lo", {31'd0, rx_busy}, 32'd0);
    idle(20);
    compare("glitch");

    // Reset in the middle of bit 4; upper bits high so the rest of the
    // frame holds the line high and cannot start a new frame.
    fr = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(fr[i]);
    rx = fr[4];
    idle(HALF);
    chk("midframe_busy", {31'd0, rx_busy}, 32'd1);
    resetn = 1'b0;
    idle(1);
    chk("mrst_data",  {24'd0, rx_data}, 32'd0);
    chk("mrst_valid", {31'd0, rx_valid}, 32'd0);
    chk("mrst_ferr",  {31'd0, frame_err}, 32'd0);
    chk("mrst_busy",  {31'd0, rx_busy}, 32'd0);
    model_data = 8'h00;
    resetn = 1'b1;
    idle(TICK - HALF - 1);
    for (int i = 5; i < 8; i++) drive_bit(fr[i]);
    drive_bit(1'b1);
    idle(200);
    compare("mid_reset");
    chk("mid_reset_data", {24'd0, rx_data}, 32'd0);

    // Random loopback-style traffic with small random gaps
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      idle($urandom_range(0, 3));
    end
    idle(5);
    compare("random");
    chk("final_data", {24'd0, rx_data}, {24'd0, model_data});
    chk("final_busy", {31'd0, rx_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
